contador_de_quantum: RTL

Quantum timer and preemption detector that sits directly upstream of the preemption manager. It generates `flag_faz_preempcao`, which returns control to the OS. It arms when the OS dispatches user program 1 or 2, then counts retired user instructions against the programmed quantum. It raises a one-cycle preemption request when the quantum expires or a HALT retires, and it records which programs have finished so the OS cannot re-dispatch them.

---
 rtl/contador_de_quantum.sv | 123 ++++++++++++
 1 files changed

// File: rtl/contador_de_quantum.sv
// contador_de_quantum: quantum timer and preemption detector.
// Arms when the OS dispatches user program 1 or 2. It then counts retired
// user instructions against the sampled quantum. When the quantum expires
// or a HALT retires, it raises a one-cycle request to return to the OS.
// Finished programs are remembered so that they cannot be dispatched again.
module contador_de_quantum #(
  parameter int unsigned          QUANTUM_W   = 5,
  parameter int unsigned          OPCODE_W    = 6,
  parameter logic [OPCODE_W-1:0]  HALT_OPCODE = 6'b111111
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           jump_prog,
  input  logic [QUANTUM_W-1:0] quantum,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 instr_valid,
  output logic                 flag_faz_preempcao,
  output logic [1:0]           motivo,
  output logic [1:0]           processo_atual,
  output logic [QUANTUM_W-1:0] restante,
  output logic                 ativo,
  output logic [1:0]           finalizado
);

  typedef enum logic [1:0] {
    OCIOSO,
    EXECUTANDO,
    PREEMPCAO
  } estado_t;

  localparam logic [1:0] MOTIVO_NENHUM  = 2'b00;
  localparam logic [1:0] MOTIVO_QUANTUM = 2'b01;
  localparam logic [1:0] MOTIVO_HALT    = 2'b10;

  localparam logic [QUANTUM_W-1:0] UM = QUANTUM_W'(1);

  estado_t              estado;
  logic                 pode_despachar;
  logic                 eh_halt;
  logic [QUANTUM_W-1:0] quantum_carga;

  // A dispatch is accepted only for programs 1 and 2 that have not halted yet
  always_comb begin
    pode_despachar = 1'b0;
    case (jump_prog)
      2'd1:    pode_despachar = ~finalizado[0];
      2'd2:    pode_despachar = ~finalizado[1];
      default: pode_despachar = 1'b0;
    endcase
  end

  // Decode HALT, and load a zero quantum as one so a program always runs at least once
  always_comb begin
    eh_halt       = (opcode == HALT_OPCODE);
    quantum_carga = (quantum == '0) ? UM : quantum;
  end

  // Single FSM: state plus all registered (Moore) outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado             <= OCIOSO;
      flag_faz_preempcao <= 1'b0;
      motivo             <= MOTIVO_NENHUM;
      processo_atual     <= 2'd0;
      restante           <= '0;
      ativo              <= 1'b0;
      finalizado         <= 2'b00;
    end else begin
      case (estado)
        OCIOSO: begin
          flag_faz_preempcao <= 1'b0;
          if (pode_despachar) begin
            estado         <= EXECUTANDO;
            processo_atual <= jump_prog;
            restante       <= quantum_carga;
            motivo         <= MOTIVO_NENHUM;
            ativo          <= 1'b1;
          end
        end

        EXECUTANDO: begin
          if (instr_valid) begin
            if (eh_halt) begin
              // HALT wins over expiry. The remaining count is left untouched.
              estado             <= PREEMPCAO;
              motivo             <= MOTIVO_HALT;
              flag_faz_preempcao <= 1'b1;
              ativo              <= 1'b0;
              if (processo_atual == 2'd2) begin
                finalizado[1] <= 1'b1;
              end else begin
                finalizado[0] <= 1'b1;
              end
            end else begin
              restante <= restante - UM;
              if (restante == UM) begin
                estado             <= PREEMPCAO;
                motivo             <= MOTIVO_QUANTUM;
                flag_faz_preempcao <= 1'b1;
                ativo              <= 1'b0;
              end
            end
          end
        end

        PREEMPCAO: begin
          estado             <= OCIOSO;
          flag_faz_preempcao <= 1'b0;
          processo_atual     <= 2'd0;
          ativo              <= 1'b0;
        end

        default: begin
          estado             <= OCIOSO;
          flag_faz_preempcao <= 1'b0;
          processo_atual     <= 2'd0;
          ativo              <= 1'b0;
        end
      endcase
    end
  end

endmodule
